// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared counter, per-channel duty compare, double-buffered
// period/duty updates at period end. Define PWM_MULTI_CENTER_EN for center-aligned (up/down) counting.
module pwm_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      LOAD,
    input  logic [WIDTH-1:0]          PERIOD,
    input  logic [CHANNELS*WIDTH-1:0] DUTY,
`ifdef PWM_MULTI_CENTER_EN
    input  logic                      CENTER,
`endif
    output logic [CHANNELS-1:0]       PWM,
    output logic [WIDTH-1:0]          CNT,
    output logic                      PEND,
    output logic                      PENDING
);

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    period_a;
    logic [WIDTH-1:0]    period_p;
    logic [WIDTH-1:0]    duty_a [CHANNELS];
    logic [WIDTH-1:0]    duty_p [CHANNELS];
    logic                pending_q;
    logic [CHANNELS-1:0] pwm_q;
    logic                at_top;
    logic                period_end;

`ifdef PWM_MULTI_CENTER_EN
    logic center_a;
    logic center_p;
    logic dir;

    // Period end sits on the down-count at 1; tiny periods (0/1) have no down leg and wrap at the top.
    always_comb begin
        period_end = 1'b0;
        if (EN) begin
            if (center_a)
                period_end = (dir && cnt == WIDTH'(1)) ||
                             (!dir && at_top && period_a <= WIDTH'(1));
            else
                period_end = at_top;
        end
    end
`else
    assign period_end = EN && at_top;
`endif

    assign at_top = (cnt >= period_a);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
`ifdef PWM_MULTI_CENTER_EN
            dir <= 1'b0;
`endif
        end else if (!EN || period_end) begin
            cnt <= '0;
`ifdef PWM_MULTI_CENTER_EN
            dir <= 1'b0;
`endif
`ifdef PWM_MULTI_CENTER_EN
        end else if (center_a && (dir || at_top)) begin
            cnt <= cnt - 1'b1;
            dir <= 1'b1;
`endif
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending capture and active update; with the counter parked, updates take effect immediately.
    always_ff @(posedge CLK) begin
        if (RST) begin
            period_a  <= '1;
            period_p  <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_a[i] <= '0;
                duty_p[i] <= '0;
            end
`ifdef PWM_MULTI_CENTER_EN
            center_a <= 1'b0;
            center_p <= 1'b0;
`endif
        end else begin
            if (LOAD) begin
                period_p <= PERIOD;
                for (int i = 0; i < CHANNELS; i++)
                    duty_p[i] <= DUTY[i*WIDTH +: WIDTH];
`ifdef PWM_MULTI_CENTER_EN
                center_p <= CENTER;
`endif
            end

            if (!EN) begin
                if (LOAD) begin
                    period_a <= PERIOD;
                    for (int i = 0; i < CHANNELS; i++)
                        duty_a[i] <= DUTY[i*WIDTH +: WIDTH];
`ifdef PWM_MULTI_CENTER_EN
                    center_a <= CENTER;
`endif
                end else if (pending_q) begin
                    period_a <= period_p;
                    for (int i = 0; i < CHANNELS; i++)
                        duty_a[i] <= duty_p[i];
`ifdef PWM_MULTI_CENTER_EN
                    center_a <= center_p;
`endif
                end
                pending_q <= 1'b0;
            end else if (period_end && pending_q) begin
                period_a <= period_p;
                for (int i = 0; i < CHANNELS; i++)
                    duty_a[i] <= duty_p[i];
`ifdef PWM_MULTI_CENTER_EN
                center_a <= center_p;
`endif
                // A LOAD landing on this edge stays pending for the next period.
                pending_q <= LOAD;
            end else if (LOAD) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Compare in WIDTH+1 bits so duty beyond the period reads as constant high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                pwm_q[i] <= EN && ({1'b0, cnt} < {1'b0, duty_a[i]});
        end
    end

    assign PWM     = pwm_q;
    assign CNT     = cnt;
    assign PEND    = period_end;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (WIDTH=4, CHANNELS=4); center-aligned steps run when
// PWM_MULTI_CENTER_EN is defined.
module tb_pwm_multi;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        LOAD;
    logic [3:0]  PERIOD;
    logic [15:0] DUTY;
`ifdef PWM_MULTI_CENTER_EN
    logic        CENTER;
`endif
    logic [3:0]  PWM;
    logic [3:0]  CNT;
    logic        PEND;
    logic        PENDING;

    int tests = 0;
    int fails = 0;
    int k = 0;

    pwm_multi #(.WIDTH(4), .CHANNELS(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .EN(EN),
        .LOAD(LOAD),
        .PERIOD(PERIOD),
        .DUTY(DUTY),
`ifdef PWM_MULTI_CENTER_EN
        .CENTER(CENTER),
`endif
        .PWM(PWM),
        .CNT(CNT),
        .PEND(PEND),
        .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles of an edge-mode run (period per+1) with ch0 duty d0;
    // ch1=10 and ch2=15 stay high, ch3=0 stays low.
    task automatic cycles(input int n, input int d0, input int per);
        for (int j = 0; j < n; j++) begin
            @(negedge CLK);
            k++;
            chk("run_cnt", CNT, k % (per + 1));
            chk("run_pwm0", PWM[0], ((k - 1) % (per + 1)) < d0);
            chk("run_pwm_hi", PWM[3:1], 3'b011);
            chk("run_pend", PEND, (k % (per + 1)) == per);
        end
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; PERIOD = '0; DUTY = '0;
`ifdef PWM_MULTI_CENTER_EN
        CENTER = 1'b0;
`endif
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_cnt", CNT, 0);
        chk("rst_pwm", PWM, 0);
        chk("rst_pending", PENDING, 0);
        chk("rst_pend", PEND, 0);

        // Load while parked goes straight to active.
        RST = 1'b0; LOAD = 1'b1; PERIOD = 4'd9; DUTY = 16'h0FA3;
        @(negedge CLK);
        LOAD = 1'b0;
        chk("park_pending", PENDING, 0);
        chk("park_cnt", CNT, 0);
        chk("park_pwm", PWM, 0);
        EN = 1'b1;
        #1;
        chk("start_pend", PEND, 0);

        cycles(24, 3, 9);                 // k=24 -> CNT=4

        LOAD = 1'b1; DUTY = 16'h0FA7;     // mid-period load
        cycles(1, 3, 9);
        LOAD = 1'b0;
        chk("mid_pending", PENDING, 1);
        cycles(4, 3, 9);                  // k=29 -> CNT=9, period end
        chk("old_duty_pending", PENDING, 1);

        LOAD = 1'b1; DUTY = 16'h0FA5;     // load on the period-end cycle
        cycles(1, 3, 9);
        LOAD = 1'b0;
        chk("pe_load_pending", PENDING, 1);
        cycles(10, 7, 9);                 // new duty 7, then 5 applied at k=40
        chk("pe_applied_pending", PENDING, 0);
        cycles(5, 5, 9);                  // k=45 -> CNT=5

        LOAD = 1'b1; DUTY = 16'h0FA2;
        cycles(1, 5, 9);                  // CNT=6
        chk("prerst_pending", PENDING, 1);

        // Reset overrides a simultaneous LOAD and discards pending values.
        RST = 1'b1; LOAD = 1'b1; PERIOD = 4'd3; DUTY = 16'hFFFF;
        @(negedge CLK);
        chk("rst2_cnt", CNT, 0);
        chk("rst2_pwm", PWM, 0);
        chk("rst2_pending", PENDING, 0);
        RST = 1'b0; LOAD = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            @(negedge CLK);
            chk("post_rst_cnt", CNT, j);
            chk("post_rst_pwm", PWM, 0);
            chk("post_rst_pend", PEND, j == 15);
        end

        EN = 1'b0;
        #1;
        chk("en0_pend", PEND, 0);
        LOAD = 1'b1; PERIOD = 4'd0; DUTY = 16'h0120;
        @(negedge CLK);
        LOAD = 1'b0;
        chk("en0_cnt", CNT, 0);
        chk("en0_pwm", PWM, 0);
        chk("en0_pending", PENDING, 0);

        // Zero period: counter pinned at 0, period end every cycle.
        EN = 1'b1;
        #1;
        chk("p0_pend_first", PEND, 1);
        for (int j = 0; j < 3; j++) begin
            @(negedge CLK);
            chk("p0_cnt", CNT, 0);
            chk("p0_pwm", PWM, 4'b0110);
            chk("p0_pend", PEND, 1);
        end

`ifdef PWM_MULTI_CENTER_EN
        begin
            int exp_c [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
            int exp_w [8] = '{1, 1, 0, 0, 0, 0, 0, 1};
            int exp_e [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
            EN = 1'b0; LOAD = 1'b1; CENTER = 1'b1; PERIOD = 4'd4; DUTY = 16'h0002;
            @(negedge CLK);
            LOAD = 1'b0; EN = 1'b1;
            #1;
            chk("ctr_start_pend", PEND, 0);
            for (int j = 0; j < 16; j++) begin
                @(negedge CLK);
                chk("ctr_cnt", CNT, exp_c[j % 8]);
                chk("ctr_pwm0", PWM[0], exp_w[j % 8]);
                chk("ctr_pend", PEND, exp_e[j % 8]);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
